// File: rtl/counter_pkg.sv
// Shared constants for the bounded up/down counter tile.
package counter_pkg;

  localparam int unsigned BW_DEFAULT = 3;
  localparam int unsigned PW_DEFAULT = 4;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: emits one tick every div_i+1 enabled cycles.
module counter_prescaler #(
  parameter int unsigned PW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [PW-1:0] div_i,
  output logic          tick_o
);

  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;

  // >= rather than == so that lowering div_i mid-period fires promptly.
  always_comb begin
    tick_o = en_i && (pcnt_q >= div_i);
    pcnt_d = pcnt_q;
    if (clr_i) begin
      pcnt_d = '0;
    end else if (en_i) begin
      pcnt_d = tick_o ? '0 : pcnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/tt_um_counter_updown.sv
// Bounded up/down counter with wrap/saturate modes, parallel load and prescaler.
module tt_um_counter_updown
  import counter_pkg::*;
#(
  parameter int unsigned BW = BW_DEFAULT,
  parameter int unsigned PW = PW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          up_i,
  input  logic          sat_i,
  input  logic [BW-1:0] max_i,
  input  logic [PW-1:0] div_i,
  input  logic          load_i,
  input  logic [BW-1:0] load_val_i,
  output logic [BW-1:0] counter_val_o,
  output logic          wrap_o,
  output logic          at_limit_o
);

  logic          tick;
  logic [BW-1:0] cnt_q;
  logic [BW-1:0] cnt_d;
  logic          wrap_q;
  logic          wrap_d;

  counter_prescaler #(
    .PW (PW)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .clr_i  (load_i),
    .div_i  (div_i),
    .tick_o (tick)
  );

  // Load beats a count step; bound compare precedes any increment.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load_i) begin
      cnt_d = (load_val_i > max_i) ? max_i : load_val_i;
    end else if (tick) begin
      if (up_i) begin
        if (cnt_q < max_i) begin
          cnt_d = cnt_q + BW'(1);
        end else if (sat_i == MODE_SAT) begin
          cnt_d = max_i;
        end else begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - BW'(1);
        end else if (sat_i == MODE_WRAP) begin
          cnt_d  = max_i;
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign counter_val_o = cnt_q;
  assign wrap_o        = wrap_q;
  assign at_limit_o    = (up_i && (cnt_q >= max_i)) || (!up_i && (cnt_q == '0));

endmodule

// File: tb/tb_tt_um_counter_updown.sv
// Directed and randomized checks of tt_um_counter_updown against an arithmetic reference model.
module tb_tt_um_counter_updown;

  localparam int unsigned BW = 3;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          en_i = 1'b0;
  logic          up_i = 1'b1;
  logic          sat_i = 1'b0;
  logic [BW-1:0] max_i = 3'd7;
  logic [PW-1:0] div_i = '0;
  logic          load_i = 1'b0;
  logic [BW-1:0] load_val_i = '0;
  logic [BW-1:0] counter_val_o;
  logic          wrap_o;
  logic          at_limit_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_cnt  = 0;
  int m_pcnt = 0;
  int m_wrap = 0;

  always #5 clk = ~clk;

  tt_um_counter_updown #(
    .BW (BW),
    .PW (PW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .up_i          (up_i),
    .sat_i         (sat_i),
    .max_i         (max_i),
    .div_i         (div_i),
    .load_i        (load_i),
    .load_val_i    (load_val_i),
    .counter_val_o (counter_val_o),
    .wrap_o        (wrap_o),
    .at_limit_o    (at_limit_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: check the combinational flag, advance the model, check registered outputs.
  task automatic cycle();
    int mx, dv, lim;
    bit tick;
    #1;
    mx  = int'(max_i);
    dv  = int'(div_i);
    lim = ((up_i && m_cnt >= mx) || (!up_i && m_cnt == 0)) ? 1 : 0;
    chk("at_limit", 32'(at_limit_o), 32'(lim));
    @(posedge clk);
    if (rst_i) begin
      m_cnt = 0; m_pcnt = 0; m_wrap = 0;
    end else if (load_i) begin
      m_cnt  = (int'(load_val_i) < mx) ? int'(load_val_i) : mx;
      m_pcnt = 0;
      m_wrap = 0;
    end else begin
      tick   = en_i && (m_pcnt >= dv);
      m_wrap = 0;
      if (en_i) m_pcnt = tick ? 0 : m_pcnt + 1;
      if (tick) begin
        if (up_i) begin
          if (m_cnt < mx) m_cnt = m_cnt + 1;
          else if (sat_i) m_cnt = mx;
          else begin m_cnt = 0; m_wrap = 1; end
        end else begin
          if (m_cnt > 0) m_cnt = m_cnt - 1;
          else if (!sat_i) begin m_cnt = mx; m_wrap = 1; end
        end
      end
    end
    #1;
    chk("counter_val", 32'(counter_val_o), 32'(m_cnt));
    chk("wrap", 32'(wrap_o), 32'(m_wrap));
  endtask

  initial begin
    int wraps;
    int exp_seq [4];
    int exp_wrp [4];

    // Reset state
    cycle();
    cycle();
    chk("reset_cnt", 32'(counter_val_o), 32'd0);
    chk("reset_wrap", 32'(wrap_o), 32'd0);

    // Basic up count with wrap
    rst_i = 1'b0; en_i = 1'b1; up_i = 1'b1; sat_i = 1'b0; max_i = 3'd7; div_i = '0;
    cycle();
    chk("first_step", 32'(counter_val_o), 32'd1);
    wraps = 0;
    for (int i = 1; i < 40; i++) begin
      cycle();
      if (wrap_o) wraps++;
    end
    chk("wrap_count", 32'(wraps), 32'd5);

    // Saturate up, then lower the bound below the count
    load_i = 1'b1; load_val_i = 3'd0;
    cycle();
    load_i = 1'b0; sat_i = 1'b1; max_i = 3'd5;
    for (int i = 0; i < 8; i++) cycle();
    chk("sat_hold", 32'(counter_val_o), 32'd5);
    chk("sat_wrap", 32'(wrap_o), 32'd0);
    #1;
    chk("sat_limit", 32'(at_limit_o), 32'd1);
    max_i = 3'd3;
    cycle();
    chk("sat_clamp", 32'(counter_val_o), 32'd3);

    // Down count with wrap to max
    sat_i = 1'b0; max_i = 3'd6; load_i = 1'b1; load_val_i = 3'd2;
    cycle();
    chk("load_2", 32'(counter_val_o), 32'd2);
    load_i = 1'b0; up_i = 1'b0;
    exp_seq = '{1, 0, 6, 5};
    exp_wrp = '{0, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("down_seq", 32'(counter_val_o), 32'(exp_seq[i]));
      chk("down_wrap", 32'(wrap_o), 32'(exp_wrp[i]));
    end

    // Prescaler with an enable gap mid-period
    up_i = 1'b1; max_i = 3'd7; div_i = 4'd2; load_i = 1'b1; load_val_i = 3'd0;
    cycle();
    load_i = 1'b0;
    cycle(); cycle();
    chk("pre_hold", 32'(counter_val_o), 32'd0);
    cycle();
    chk("pre_step1", 32'(counter_val_o), 32'd1);
    cycle();
    en_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    en_i = 1'b1;
    cycle();
    chk("pre_resume_hold", 32'(counter_val_o), 32'd1);
    cycle();
    chk("pre_step2", 32'(counter_val_o), 32'd2);

    // Load clamps to max and beats a concurrent tick; reset beats load
    max_i = 3'd4; load_i = 1'b1; load_val_i = 3'd7;
    cycle();
    chk("load_clamp", 32'(counter_val_o), 32'd4);
    div_i = '0; load_val_i = 3'd1;
    cycle();
    chk("load_wins", 32'(counter_val_o), 32'd1);
    sat_i = 1'b0; max_i = 3'd1; load_i = 1'b0;
    cycle();
    rst_i = 1'b1; load_i = 1'b1; load_val_i = 3'd3;
    cycle();
    chk("rst_load_cnt", 32'(counter_val_o), 32'd0);
    chk("rst_load_wrap", 32'(wrap_o), 32'd0);

    // Reset mid-count and mid-prescale
    rst_i = 1'b0; load_i = 1'b1; load_val_i = 3'd5; max_i = 3'd7; div_i = 4'd1;
    cycle();
    load_i = 1'b0;
    cycle(); cycle(); cycle();
    chk("mid_cnt", 32'(counter_val_o), 32'd6);
    rst_i = 1'b1;
    cycle();
    chk("mid_rst", 32'(counter_val_o), 32'd0);
    rst_i = 1'b0;
    cycle();
    chk("mid_rel_hold", 32'(counter_val_o), 32'd0);
    cycle();
    chk("mid_rel_step", 32'(counter_val_o), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_i      = ($urandom_range(0, 49) == 0);
      load_i     = ($urandom_range(0, 11) == 0);
      en_i       = ($urandom_range(0, 4) != 0);
      up_i       = 1'($urandom);
      sat_i      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) max_i = BW'($urandom);
      div_i      = PW'($urandom_range(0, 3));
      load_val_i = BW'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
